// File: rtl/arm_mc_pkg.sv
// rtl/arm_mc_pkg.sv - shared types and encodings for the ARM multicycle control unit
// Holds the main FSM state enum, ALU operation enum, instruction field codes
// (op, data-processing cmd, condition) and datapath mux-select constants.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctl_t;

    // op[27:26]
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // data-processing cmd[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // cond[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // datapath mux selects
    localparam logic       SRCA_REG    = 1'b0;
    localparam logic       SRCA_PC     = 1'b1;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    localparam logic       ADDR_PC     = 1'b0;
    localparam logic       ADDR_RESULT = 1'b1;
    localparam logic [1:0] IMM_8       = 2'b00;
    localparam logic [1:0] IMM_12      = 2'b01;
    localparam logic [1:0] IMM_24      = 2'b10;

endpackage

// File: rtl/arm_multicycle_control_unit_if.sv
// rtl/arm_multicycle_control_unit_if.sv - instruction/flag inputs and datapath control bundle
// Ports: i_Instr, i_ALU_Flags (into the control unit); o_PC_Write, o_MemWrite,
// o_RegWrite, o_InstructionWrite, o_AddressSrc, o_ALU_Src_A, o_RegSrc,
// o_ImmediateSrc, o_ALU_Src_B, o_ALU_Control, o_ResultSrc (out of it).
// master = control unit side, slave = datapath side.
interface arm_multicycle_control_unit_if;

    logic [31:0] i_Instr;
    logic [3:0]  i_ALU_Flags;
    logic        o_PC_Write;
    logic        o_MemWrite;
    logic        o_RegWrite;
    logic        o_InstructionWrite;
    logic        o_AddressSrc;
    logic        o_ALU_Src_A;
    logic [1:0]  o_RegSrc;
    logic [1:0]  o_ImmediateSrc;
    logic [1:0]  o_ALU_Src_B;
    logic [1:0]  o_ALU_Control;
    logic [1:0]  o_ResultSrc;

    modport master (
        input  i_Instr, i_ALU_Flags,
        output o_PC_Write, o_MemWrite, o_RegWrite, o_InstructionWrite,
               o_AddressSrc, o_ALU_Src_A, o_RegSrc, o_ImmediateSrc,
               o_ALU_Src_B, o_ALU_Control, o_ResultSrc
    );

    modport slave (
        output i_Instr, i_ALU_Flags,
        input  o_PC_Write, o_MemWrite, o_RegWrite, o_InstructionWrite,
               o_AddressSrc, o_ALU_Src_A, o_RegSrc, o_ImmediateSrc,
               o_ALU_Src_B, o_ALU_Control, o_ResultSrc
    );

endinterface

// File: rtl/arm_mc_cond_logic.sv
// rtl/arm_mc_cond_logic.sv - NZCV flag register, condition evaluation, CondEx register
// Ports: i_CLK, i_NRESET (async active-low); i_cond condition field;
// i_alu_flags ALU NZCV; i_cond_latch (capture CondEx, asserted in DECODE);
// i_flag_write_req (flag update wanted, gated here by CondEx); o_cond_ex.
module arm_mc_cond_logic
    import arm_mc_pkg::*;
(
    input  logic       i_CLK,
    input  logic       i_NRESET,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_cond_latch,
    input  logic       i_flag_write_req,
    output logic       o_cond_ex
);

    logic [3:0] flags_q;
    logic       cond_ex_q;
    logic       cond_now;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_now = 1'b0;
        case (i_cond)
            COND_EQ: cond_now = z_f;
            COND_NE: cond_now = !z_f;
            COND_CS: cond_now = c_f;
            COND_CC: cond_now = !c_f;
            COND_MI: cond_now = n_f;
            COND_PL: cond_now = !n_f;
            COND_VS: cond_now = v_f;
            COND_VC: cond_now = !v_f;
            COND_HI: cond_now = c_f && !z_f;
            COND_LS: cond_now = !c_f || z_f;
            COND_GE: cond_now = (n_f == v_f);
            COND_LT: cond_now = (n_f != v_f);
            COND_GT: cond_now = !z_f && (n_f == v_f);
            COND_LE: cond_now = z_f || (n_f != v_f);
            COND_AL: cond_now = 1'b1;
            default: cond_now = 1'b0;    // 1111 never executes
        endcase
    end

    // CondEx is frozen at the end of DECODE so later flag updates in the
    // same instruction cannot change whether it executes.
    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            if (i_cond_latch) begin
                cond_ex_q <= cond_now;
            end
            if (i_flag_write_req && cond_ex_q) begin
                flags_q <= i_alu_flags;
            end
        end
    end

    assign o_cond_ex = cond_ex_q;

endmodule

// File: rtl/arm_multicycle_control_unit.sv
// rtl/arm_multicycle_control_unit.sv - multicycle ARM main FSM and instruction decoder
// Ports: i_CLK rising-edge clock; i_NRESET async active-low reset;
// bus (master modport): instruction/ALU flags in, datapath strobes and mux selects out.
// Latencies: DP 4, LDR 5, STR 4, B 3 cycles; undefined op returns after DECODE.
module arm_multicycle_control_unit
    import arm_mc_pkg::*;
(
    input  logic                          i_CLK,
    input  logic                          i_NRESET,
    arm_multicycle_control_unit_if.master bus
);

    state_t     state, state_next;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       s_bit, l_bit, u_bit;
    logic       unused_instr_bits;

    logic       cond_ex;
    logic       is_exec;
    alu_ctl_t   dp_alu;
    logic       dp_supported;
    logic       dp_writes_rd;
    logic       is_cmp;

    logic       pc_write, mem_write, reg_write, instr_write;
    logic       address_src, alu_src_a;
    logic [1:0] imm_src, alu_src_b, result_src;
    alu_ctl_t   alu_ctl;

    assign cond  = bus.i_Instr[31:28];
    assign op    = bus.i_Instr[27:26];
    assign funct = bus.i_Instr[25:20];
    assign cmd   = bus.i_Instr[24:21];
    assign u_bit = bus.i_Instr[23];
    assign s_bit = funct[0];
    assign l_bit = funct[0];
    assign rd    = bus.i_Instr[15:12];
    assign unused_instr_bits = ^{bus.i_Instr[19:16], bus.i_Instr[11:0]};

    // data-processing command decode; unsupported cmds become a NOP that
    // still walks EXEC -> ALUWB but writes neither Rd nor flags
    always_comb begin
        dp_alu       = ALU_ADD;
        dp_supported = 1'b1;
        dp_writes_rd = 1'b1;
        is_cmp       = 1'b0;
        case (cmd)
            CMD_ADD: dp_alu = ALU_ADD;
            CMD_SUB: dp_alu = ALU_SUB;
            CMD_AND: dp_alu = ALU_AND;
            CMD_ORR: dp_alu = ALU_ORR;
            CMD_CMP: begin
                dp_alu       = ALU_SUB;
                dp_writes_rd = 1'b0;
                is_cmp       = 1'b1;
            end
            default: begin
                dp_supported = 1'b0;
                dp_writes_rd = 1'b0;
            end
        endcase
    end

    assign is_exec = (state == S_EXECR) || (state == S_EXECI);

    arm_mc_cond_logic u_cond_logic (
        .i_CLK            (i_CLK),
        .i_NRESET         (i_NRESET),
        .i_cond           (cond),
        .i_alu_flags      (bus.i_ALU_Flags),
        .i_cond_latch     (state == S_DECODE),
        .i_flag_write_req (is_exec && dp_supported && (s_bit || is_cmp)),
        .o_cond_ex        (cond_ex)
    );

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:   state_next = S_MEMADR;
                    OP_DP:    state_next = funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:    state_next = S_BRANCH;
                    OP_UNDEF: state_next = S_FETCH;
                    default:  state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = l_bit ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_next = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_next = S_ALUWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        instr_write = 1'b0;
        address_src = ADDR_PC;
        alu_src_a   = SRCA_REG;
        imm_src     = IMM_8;
        alu_src_b   = SRCB_REG;
        alu_ctl     = ALU_ADD;
        result_src  = RES_ALUOUT;
        case (state)
            S_FETCH: begin
                instr_write = 1'b1;
                pc_write    = 1'b1;
                address_src = ADDR_PC;
                alu_src_a   = SRCA_PC;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_12;
                alu_ctl   = u_bit ? ALU_ADD : ALU_SUB;
            end
            S_MEMREAD: begin
                address_src = ADDR_RESULT;
                result_src  = RES_ALUOUT;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = cond_ex && (rd != 4'hF);
            end
            S_MEMWRITE: begin
                address_src = ADDR_RESULT;
                result_src  = RES_ALUOUT;
                mem_write   = cond_ex;
            end
            S_EXECR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_REG;
                alu_ctl   = dp_alu;
            end
            S_EXECI: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_8;
                alu_ctl   = dp_alu;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = cond_ex && dp_writes_rd && (rd != 4'hF);
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_24;
                alu_ctl    = ALU_ADD;
                result_src = RES_ALU;
                pc_write   = cond_ex;
            end
            default: ;
        endcase
        // state is already FETCH while reset is low; keep its strobes quiet
        if (!i_NRESET) begin
            pc_write    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            instr_write = 1'b0;
        end
    end

    assign bus.o_PC_Write         = pc_write;
    assign bus.o_MemWrite         = mem_write;
    assign bus.o_RegWrite         = reg_write;
    assign bus.o_InstructionWrite = instr_write;
    assign bus.o_AddressSrc       = address_src;
    assign bus.o_ALU_Src_A        = alu_src_a;
    assign bus.o_ImmediateSrc     = imm_src;
    assign bus.o_ALU_Src_B        = alu_src_b;
    assign bus.o_ALU_Control      = alu_ctl;
    assign bus.o_ResultSrc        = result_src;
    // register-file read port selects follow the instruction register
    assign bus.o_RegSrc           = {(op == OP_MEM) && !l_bit, (op == OP_BR)};

endmodule

// File: tb/tb_arm_multicycle_control_unit.sv
// tb/tb_arm_multicycle_control_unit.sv - directed self-checking bench for arm_multicycle_control_unit
module tb_arm_multicycle_control_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    arm_multicycle_control_unit_if bus ();

    arm_multicycle_control_unit dut (
        .i_CLK    (clk),
        .i_NRESET (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // {PCW, MW, RW, IW, AddrSrc, SrcA, RegSrc, ImmSrc, SrcB, ALUCtl, ResSrc}
    localparam logic [15:0] F_00  = 16'b100101_00_00_10_00_10;
    localparam logic [15:0] D_00  = 16'b000001_00_00_10_00_10;
    localparam logic [15:0] F_10  = 16'b100101_10_00_10_00_10;
    localparam logic [15:0] D_10  = 16'b000001_10_00_10_00_10;
    localparam logic [15:0] F_01  = 16'b100101_01_00_10_00_10;
    localparam logic [15:0] D_01  = 16'b000001_01_00_10_00_10;
    localparam logic [15:0] ZERO  = 16'b000000_00_00_00_00_00;
    localparam logic [15:0] EXI   = 16'b000000_00_00_01_00_00;
    localparam logic [15:0] BR_T  = 16'b100000_01_10_01_00_10;
    localparam logic [15:0] BR_N  = 16'b000000_01_10_01_00_10;

    logic [15:0] tr [16];
    int          n_cyc;

    function automatic logic [15:0] pack();
        return {bus.o_PC_Write, bus.o_MemWrite, bus.o_RegWrite, bus.o_InstructionWrite,
                bus.o_AddressSrc, bus.o_ALU_Src_A, bus.o_RegSrc, bus.o_ImmediateSrc,
                bus.o_ALU_Src_B, bus.o_ALU_Control, bus.o_ResultSrc};
    endfunction

    // Called at a falling edge while in FETCH; records one word per cycle
    // until the next FETCH (bounded at 12 cycles).
    task automatic run_instr(input logic [31:0] instr, input logic [3:0] flags);
        bus.i_Instr     = instr;
        bus.i_ALU_Flags = flags;
        #1;
        tr[0] = pack();
        n_cyc = 1;
        for (int k = 1; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (bus.o_InstructionWrite) break;
            tr[k] = pack();
            n_cyc++;
        end
    endtask

    task automatic test_reset();
        bus.i_Instr     = 32'h0;
        bus.i_ALU_Flags = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (pack() !== D_00) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", pack(), D_00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (pack() !== F_00) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", pack(), F_00);
        end
    endtask

    task automatic test_dp_imm();
        logic [15:0] exp [4];
        exp = '{F_00, D_00, EXI, 16'b001000_00_00_00_00_00};
        run_instr(32'hE2821005, 4'b0000);
        checks++;
        if (n_cyc !== 4) begin
            failures++;
            $display("FAIL add_imm_len got=%0d exp=4", n_cyc);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tr[k] !== exp[k]) begin
                failures++;
                $display("FAIL add_imm[%0d] got=%b exp=%b", k, tr[k], exp[k]);
            end
        end
    endtask

    task automatic test_ldr();
        logic [15:0] exp [5];
        exp = '{F_00, D_00, 16'b000000_00_01_01_00_00,
                16'b000010_00_00_00_00_00, 16'b001000_00_00_00_00_01};
        run_instr(32'hE5910008, 4'b0000);
        checks++;
        if (n_cyc !== 5) begin
            failures++;
            $display("FAIL ldr_len got=%0d exp=5", n_cyc);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (tr[k] !== exp[k]) begin
                failures++;
                $display("FAIL ldr[%0d] got=%b exp=%b", k, tr[k], exp[k]);
            end
        end
    endtask

    task automatic test_str();
        logic [15:0] exp [4];
        exp = '{F_10, D_10, 16'b000000_10_01_01_00_00, 16'b010010_10_00_00_00_00};
        run_instr(32'hE5810004, 4'b0000);
        checks++;
        if (n_cyc !== 4) begin
            failures++;
            $display("FAIL str_len got=%0d exp=4", n_cyc);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tr[k] !== exp[k]) begin
                failures++;
                $display("FAIL str[%0d] got=%b exp=%b", k, tr[k], exp[k]);
            end
        end
    endtask

    task automatic test_cmp_branch();
        logic [15:0] exp [4];
        exp = '{F_00, D_00, 16'b000000_00_00_00_01_00, ZERO};
        run_instr(32'hE1510001, 4'b0100);
        checks++;
        if (n_cyc !== 4) begin
            failures++;
            $display("FAIL cmp_len got=%0d exp=4", n_cyc);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tr[k] !== exp[k]) begin
                failures++;
                $display("FAIL cmp[%0d] got=%b exp=%b", k, tr[k], exp[k]);
            end
        end
        run_instr(32'h0A000002, 4'b0000);
        checks++;
        if (n_cyc !== 3 || tr[0] !== F_01 || tr[1] !== D_01 || tr[2] !== BR_T) begin
            failures++;
            $display("FAIL beq_taken len=%0d br=%b exp_len=3 exp_br=%b", n_cyc, tr[2], BR_T);
        end
        run_instr(32'h1A000002, 4'b0000);
        checks++;
        if (n_cyc !== 3 || tr[2] !== BR_N) begin
            failures++;
            $display("FAIL bne_not_taken len=%0d br=%b exp_len=3 exp_br=%b", n_cyc, tr[2], BR_N);
        end
        run_instr(32'hFA000002, 4'b0000);
        checks++;
        if (n_cyc !== 3 || tr[2] !== BR_N) begin
            failures++;
            $display("FAIL cond_nv len=%0d br=%b exp_len=3 exp_br=%b", n_cyc, tr[2], BR_N);
        end
    endtask

    task automatic test_cond_suppress();
        run_instr(32'hE1510001, 4'b0100);
        run_instr(32'h12821005, 4'b0000);
        checks++;
        if (n_cyc !== 4 || tr[2] !== EXI || tr[3] !== ZERO) begin
            failures++;
            $display("FAIL addne_skip len=%0d wb=%b exp_len=4 exp_wb=%b", n_cyc, tr[3], ZERO);
        end
        run_instr(32'hE282F005, 4'b0000);
        checks++;
        if (n_cyc !== 4 || tr[3] !== ZERO) begin
            failures++;
            $display("FAIL rd15_no_write len=%0d wb=%b exp_len=4 exp_wb=%b", n_cyc, tr[3], ZERO);
        end
    endtask

    task automatic test_nop_and_undef();
        run_instr(32'hE1510001, 4'b0100);
        // MOVS-style cmd is unsupported: no Rd write, and the S bit must not clobber Z
        run_instr(32'hE3B01005, 4'b0000);
        checks++;
        if (n_cyc !== 4 || tr[2] !== EXI || tr[3] !== ZERO) begin
            failures++;
            $display("FAIL nop_dp len=%0d ex=%b wb=%b exp_len=4 exp_ex=%b exp_wb=%b",
                     n_cyc, tr[2], tr[3], EXI, ZERO);
        end
        run_instr(32'h0A000002, 4'b0000);
        checks++;
        if (tr[2] !== BR_T) begin
            failures++;
            $display("FAIL nop_kept_flags got=%b exp=%b", tr[2], BR_T);
        end
        run_instr(32'hEC000000, 4'b0000);
        checks++;
        if (n_cyc !== 2 || tr[1] !== D_00) begin
            failures++;
            $display("FAIL undef_op len=%0d dec=%b exp_len=2 exp_dec=%b", n_cyc, tr[1], D_00);
        end
    endtask

    task automatic test_reset_mid();
        run_instr(32'hE1510001, 4'b0100);
        bus.i_Instr     = 32'hE5910008;
        bus.i_ALU_Flags = 4'b0000;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        checks++;
        if (pack() !== 16'b000010_00_00_00_00_00) begin
            failures++;
            $display("FAIL mid_memread got=%b exp=%b", pack(), 16'b000010_00_00_00_00_00);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pack() !== D_00) begin
            failures++;
            $display("FAIL mid_reset_async got=%b exp=%b", pack(), D_00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (pack() !== F_00) begin
            failures++;
            $display("FAIL mid_reset_release got=%b exp=%b", pack(), F_00);
        end
        run_instr(32'h0A000002, 4'b0000);
        checks++;
        if (n_cyc !== 3 || tr[2] !== BR_N) begin
            failures++;
            $display("FAIL flags_cleared_beq len=%0d br=%b exp=%b", n_cyc, tr[2], BR_N);
        end
        run_instr(32'h1A000002, 4'b0000);
        checks++;
        if (n_cyc !== 3 || tr[2] !== BR_T) begin
            failures++;
            $display("FAIL flags_cleared_bne len=%0d br=%b exp=%b", n_cyc, tr[2], BR_T);
        end
    endtask

    initial begin
        test_reset();
        test_dp_imm();
        test_ldr();
        test_str();
        test_cmp_branch();
        test_cond_suppress();
        test_nop_and_undef();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
